pmem_arbiter: RTL and testbench

//  Shares the single physical-memory port (DPI-backed pmem read/write) between IFU and LSU.

---
 rtl/pmem_arbiter.sv | 124 ++++++++++++
 tb/tb_pmem_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one physical-memory port between IFU (read-only) and LSU.
// A single transaction is in flight at a time. After a request is accepted the
// block waits, strobes pmem for exactly one cycle, then holds the response until
// the owner takes it. The accept cycle counts as the first wait cycle, so the pmem
// strobe lands max(LAT,1) cycles after accept and the response one cycle later.
module pmem_arbiter #(
   parameter int LAT = 1,          // wait cycles between accept and pmem access (0..15)
   parameter bit RR  = 1'b1        // 1 = round-robin, 0 = LSU has fixed priority
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ifu_req_valid,
   output logic        ifu_req_ready,
   input  logic [31:0] ifu_addr,
   output logic        ifu_resp_valid,
   input  logic        ifu_resp_ready,
   output logic [31:0] ifu_rdata,
   input  logic        lsu_req_valid,
   output logic        lsu_req_ready,
   input  logic [31:0] lsu_addr,
   input  logic        lsu_wen,
   input  logic [31:0] lsu_wdata,
   input  logic [7:0]  lsu_wmask,
   output logic        lsu_resp_valid,
   input  logic        lsu_resp_ready,
   output logic [31:0] lsu_rdata,
   output logic        pmem_valid,
   output logic [31:0] pmem_raddr,
   output logic [31:0] pmem_waddr,
   output logic [31:0] pmem_wdata,
   output logic [7:0]  pmem_wmask,
   output logic        pmem_wen,
   input  logic [31:0] pmem_rdata
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_ACC  = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   // Wait-state count loaded on accept; only used when LAT > 1.
   localparam logic [3:0] CNT_LOAD = (LAT > 1) ? 4'(LAT - 1) : 4'd1;

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic        owner_lsu;   // owner of the in-flight transaction
   logic        ptr_lsu;     // round-robin pointer: 1 = LSU preferred next
   logic [31:0] addr_q;
   logic        wen_q;
   logic [31:0] wdata_q;
   logic [7:0]  wmask_q;
   logic [31:0] rdata_q;

   logic idle;
   logic gnt_lsu;
   logic take;
   logic resp_done;

   // Combinational arbitration; only the winner sees ready, and only in IDLE.
   always_comb begin
      idle          = rst_n && (state == S_IDLE);
      gnt_lsu       = lsu_req_valid && (!ifu_req_valid || !RR || ptr_lsu);
      lsu_req_ready = idle && gnt_lsu;
      ifu_req_ready = idle && ifu_req_valid && !gnt_lsu;
      take          = lsu_req_ready || ifu_req_ready;
      resp_done     = owner_lsu ? lsu_resp_ready : ifu_resp_ready;
   end

   // Transaction FSM plus request/response latches.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         owner_lsu <= 1'b0;
         ptr_lsu   <= 1'b0;
         addr_q    <= 32'd0;
         wen_q     <= 1'b0;
         wdata_q   <= 32'd0;
         wmask_q   <= 8'd0;
         rdata_q   <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (take) begin
                  owner_lsu <= gnt_lsu;
                  ptr_lsu   <= !gnt_lsu;
                  addr_q    <= gnt_lsu ? lsu_addr : ifu_addr;
                  wen_q     <= gnt_lsu && lsu_wen;
                  wdata_q   <= gnt_lsu ? lsu_wdata : 32'd0;
                  wmask_q   <= gnt_lsu ? lsu_wmask : 8'd0;
                  cnt       <= CNT_LOAD;
                  state     <= (LAT > 1) ? S_WAIT : S_ACC;
               end
            end
            S_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= S_ACC;
            end
            S_ACC: begin
               rdata_q <= wen_q ? 32'd0 : pmem_rdata;
               state   <= S_RESP;
            end
            default: begin
               if (resp_done) state <= S_IDLE;
            end
         endcase
      end
   end

   // Output decode: pmem port live only in ACCESS, response only to the owner in RESP.
   always_comb begin
      pmem_valid     = (state == S_ACC);
      pmem_raddr     = pmem_valid ? addr_q  : 32'd0;
      pmem_waddr     = pmem_valid ? addr_q  : 32'd0;
      pmem_wdata     = pmem_valid ? wdata_q : 32'd0;
      pmem_wmask     = pmem_valid ? wmask_q : 8'd0;
      pmem_wen       = pmem_valid && wen_q;
      lsu_resp_valid = (state == S_RESP) && owner_lsu;
      ifu_resp_valid = (state == S_RESP) && !owner_lsu;
      lsu_rdata      = lsu_resp_valid ? rdata_q : 32'd0;
      ifu_rdata      = ifu_resp_valid ? rdata_q : 32'd0;
   end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: four instances with different LAT/RR settings, each
// driven by directed and random transactions and checked cycle by cycle against
// a transaction-level model (strobe offset, response data, grant order).
module tb_pmem_arbiter;

   localparam int ND = 4;

   function automatic int lat_of(input int d);
      return (d == 2) ? 3 : ((d == 3) ? 0 : 1);
   endfunction
   function automatic bit rr_of(input int d);
      return (d == 1) ? 1'b0 : 1'b1;
   endfunction
   // pmem content model: fixed function of address
   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a == 32'h8000_0000) ? 32'hDEAD_BEEF : ({a[15:0], a[31:16]} ^ 32'h5A5A_1234);
   endfunction

   logic        clk = 1'b0;
   logic        rst_n [ND];
   logic        ifu_req_valid [ND], ifu_req_ready [ND], ifu_resp_valid [ND], ifu_resp_ready [ND];
   logic [31:0] ifu_addr [ND], ifu_rdata [ND];
   logic        lsu_req_valid [ND], lsu_req_ready [ND], lsu_wen [ND], lsu_resp_valid [ND], lsu_resp_ready [ND];
   logic [31:0] lsu_addr [ND], lsu_wdata [ND], lsu_rdata [ND];
   logic [7:0]  lsu_wmask [ND], pmem_wmask [ND];
   logic        pmem_valid [ND], pmem_wen [ND];
   logic [31:0] pmem_raddr [ND], pmem_waddr [ND], pmem_wdata [ND], pmem_rdata [ND];

   int n_chk = 0;
   int n_fail = 0;
   bit model_ptr_lsu [ND];

   always #5 clk = ~clk;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      assign pmem_rdata[g] = memfn(pmem_raddr[g]);
      pmem_arbiter #(.LAT(lat_of(g)), .RR(rr_of(g))) u_dut (
         .clk(clk), .rst_n(rst_n[g]),
         .ifu_req_valid(ifu_req_valid[g]), .ifu_req_ready(ifu_req_ready[g]), .ifu_addr(ifu_addr[g]),
         .ifu_resp_valid(ifu_resp_valid[g]), .ifu_resp_ready(ifu_resp_ready[g]), .ifu_rdata(ifu_rdata[g]),
         .lsu_req_valid(lsu_req_valid[g]), .lsu_req_ready(lsu_req_ready[g]), .lsu_addr(lsu_addr[g]),
         .lsu_wen(lsu_wen[g]), .lsu_wdata(lsu_wdata[g]), .lsu_wmask(lsu_wmask[g]),
         .lsu_resp_valid(lsu_resp_valid[g]), .lsu_resp_ready(lsu_resp_ready[g]), .lsu_rdata(lsu_rdata[g]),
         .pmem_valid(pmem_valid[g]), .pmem_raddr(pmem_raddr[g]), .pmem_waddr(pmem_waddr[g]),
         .pmem_wdata(pmem_wdata[g]), .pmem_wmask(pmem_wmask[g]), .pmem_wen(pmem_wen[g]),
         .pmem_rdata(pmem_rdata[g])
      );
   end

   task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs(input int d);
      ifu_req_valid[d] = 0; ifu_resp_ready[d] = 0; ifu_addr[d] = 0;
      lsu_req_valid[d] = 0; lsu_resp_ready[d] = 0; lsu_addr[d] = 0;
      lsu_wen[d] = 0; lsu_wdata[d] = 0; lsu_wmask[d] = 0;
   endtask

   task automatic chk_quiet(input int d, input string tag);
      chk({tag, "_pvalid"}, d, 32'(pmem_valid[d]), 0);
      chk({tag, "_praddr"}, d, pmem_raddr[d], 0);
      chk({tag, "_pwen"}, d, 32'(pmem_wen[d]), 0);
      chk({tag, "_iresp"}, d, 32'(ifu_resp_valid[d]), 0);
      chk({tag, "_lresp"}, d, 32'(lsu_resp_valid[d]), 0);
      chk({tag, "_irdy"}, d, 32'(ifu_req_ready[d]), 0);
      chk({tag, "_lrdy"}, d, 32'(lsu_req_ready[d]), 0);
   endtask

   // One full transaction. both=1 keeps both requesters valid and lets the
   // model decide the winner; otherwise only the requester selected by lsu issues.
   // Called at 1 time unit after a posedge with the DUT idle.
   task automatic txn(input int d, input bit both, input bit lsu, input logic [31:0] iaddr,
                      input logic [31:0] laddr, input bit wen, input logic [31:0] wdata,
                      input logic [7:0] wmask, input int hold);
      bit win_lsu;
      int k;
      logic [31:0] eaddr, erd;
      win_lsu = both ? (!rr_of(d) || model_ptr_lsu[d]) : lsu;
      model_ptr_lsu[d] = !win_lsu;
      k = (lat_of(d) > 1) ? lat_of(d) : 1;
      eaddr = win_lsu ? laddr : iaddr;
      erd = (win_lsu && wen) ? 32'd0 : memfn(eaddr);
      ifu_req_valid[d] = both || !lsu; ifu_addr[d] = iaddr;
      lsu_req_valid[d] = both || lsu;  lsu_addr[d] = laddr;
      lsu_wen[d] = wen; lsu_wdata[d] = wdata; lsu_wmask[d] = wmask;
      #1;
      chk("grant_lsu", d, 32'(lsu_req_ready[d]), 32'(win_lsu));
      chk("grant_ifu", d, 32'(ifu_req_ready[d]), 32'(!win_lsu));
      tick();
      if (win_lsu) lsu_req_valid[d] = 0; else ifu_req_valid[d] = 0;
      for (int c = 1; c <= k; c++) begin
         #1;
         chk("strobe", d, 32'(pmem_valid[d]), 32'(c == k));
         chk("busy_irdy", d, 32'(ifu_req_ready[d]), 0);
         chk("busy_lrdy", d, 32'(lsu_req_ready[d]), 0);
         chk("early_resp", d, 32'(ifu_resp_valid[d] | lsu_resp_valid[d]), 0);
         if (c == k) begin
            chk("raddr", d, pmem_raddr[d], eaddr);
            chk("waddr", d, pmem_waddr[d], eaddr);
            chk("pwen", d, 32'(pmem_wen[d]), 32'(win_lsu && wen));
            if (win_lsu) begin
               chk("pwdata", d, pmem_wdata[d], wdata);
               chk("pwmask", d, 32'(pmem_wmask[d]), 32'(wmask));
            end
         end
         tick();
      end
      // a requester that shows up during the response must be ignored
      if (hold > 0) begin
         if (win_lsu) begin ifu_req_valid[d] = 1; ifu_addr[d] = 32'h1000_0000; end
         else begin lsu_req_valid[d] = 1; lsu_wen[d] = 1; lsu_addr[d] = 32'h2000_0000; end
      end
      for (int h = 0; h <= hold; h++) begin
         if (h == hold) begin
            if (win_lsu) lsu_resp_ready[d] = 1; else ifu_resp_ready[d] = 1;
         end
         #1;
         chk("resp_valid", d, 32'(win_lsu ? lsu_resp_valid[d] : ifu_resp_valid[d]), 1);
         chk("rdata", d, win_lsu ? lsu_rdata[d] : ifu_rdata[d], erd);
         chk("other_resp", d, 32'(win_lsu ? ifu_resp_valid[d] : lsu_resp_valid[d]), 0);
         chk("resp_pvalid", d, 32'(pmem_valid[d]), 0);
         chk("resp_rdy", d, 32'(ifu_req_ready[d] | lsu_req_ready[d]), 0);
         tick();
      end
      clear_inputs(d);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int d, h;
      bit both, lsu, wen;
      for (int i = 0; i < ND; i++) begin
         rst_n[i] = 0; clear_inputs(i); model_ptr_lsu[i] = 0;
      end
      tick(); tick();
      for (int i = 0; i < ND; i++) chk_quiet(i, "reset");
      for (int i = 0; i < ND; i++) rst_n[i] = 1;
      tick();

      // IFU read with LAT=1, pmem returns DEADBEEF
      txn(0, 0, 0, 32'h8000_0000, 0, 0, 0, 0, 0);
      // LSU write, response data 0
      txn(0, 0, 1, 0, 32'h8000_0010, 1, 32'h1234_5678, 8'h0F, 0);
      // continuous contention, round-robin then fixed priority
      for (int i = 0; i < 4; i++) txn(0, 1, 0, 32'h8000_0100 + 32'(i*4), 32'h8000_0200 + 32'(i*4), 0, 32'h0, 8'h0, 0);
      for (int i = 0; i < 4; i++) txn(1, 1, 0, 32'h8000_0300 + 32'(i*4), 32'h8000_0400 + 32'(i*4), 1, 32'hA5A5_0000 + 32'(i), 8'hFF, 0);
      // response held off for 5 cycles
      txn(0, 0, 1, 0, 32'h8000_0020, 0, 0, 0, 5);
      txn(0, 0, 0, 32'h8000_0024, 0, 0, 0, 0, 5);

      // LAT=3: normal read, then reset during WAIT
      txn(2, 0, 0, 32'h8000_0030, 0, 0, 0, 0, 0);
      lsu_req_valid[2] = 1; lsu_addr[2] = 32'h8000_0040; lsu_wen[2] = 1; lsu_wdata[2] = 32'hCAFE_F00D; lsu_wmask[2] = 8'h3;
      #1;
      chk("rst_pre_grant", 2, 32'(lsu_req_ready[2]), 1);
      tick();
      clear_inputs(2);
      tick();
      rst_n[2] = 0;
      tick();
      chk_quiet(2, "midrst");
      model_ptr_lsu[2] = 0;
      rst_n[2] = 1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("post_rst_pvalid", 2, 32'(pmem_valid[2]), 0);
         chk("post_rst_resp", 2, 32'(lsu_resp_valid[2] | ifu_resp_valid[2]), 0);
      end
      // pointer back on IFU after reset
      txn(2, 1, 0, 32'h8000_0050, 32'h8000_0054, 0, 0, 0, 0);

      // LAT=0 LSU read
      txn(3, 0, 1, 0, 32'h8000_0060, 0, 0, 8'h0, 0);

      // random traffic on all instances
      for (int i = 0; i < 60; i++) begin
         d = int'($urandom_range(ND - 1));
         both = 1'($urandom_range(1));
         lsu = 1'($urandom_range(1));
         wen = 1'($urandom_range(1));
         h = int'($urandom_range(2));
         txn(d, both, lsu, {$urandom, 2'b00} | 32'h8000_0000, {$urandom, 2'b00} | 32'h8000_0000,
             wen, $urandom, 8'($urandom), h);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
